// File: rtl/fpu_sched_pkg.sv
// Shared constants and types for the FPU issue/writeback scheduler.
//   ADDR_W     : register address width
//   NUM_REGS   : number of FPU registers tracked by the scoreboard
//   reg_addr_t : register address type
//   unit_id_t  : execution unit identifiers (writeback requester order)
package fpu_sched_pkg;

  localparam int unsigned ADDR_W   = 5;
  localparam int unsigned NUM_REGS = 32;

  typedef logic [ADDR_W-1:0] reg_addr_t;

  typedef enum logic [1:0] {
    UNIT_ADD = 2'd0,
    UNIT_MUL = 2'd1,
    UNIT_DIV = 2'd2
  } unit_id_t;

endpackage

// File: rtl/fpu_rr_arbiter.sv
// Round-robin arbiter: N requesters -> one-hot grant.
// The pointer names the highest-priority unit for the next cycle; it moves
// to the unit after the winner, and only when a grant is issued.
// Ports:
//   clk, rst   : clock, asynchronous active-low reset (pointer -> 0)
//   req        : request vector
//   gnt_c      : one-hot grant (combinational)
//   gnt_any_c  : any grant this cycle (combinational)
module fpu_rr_arbiter #(
  parameter int unsigned N = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  output logic [N-1:0] gnt_c,
  output logic         gnt_any_c
);

  localparam int unsigned PTR_W = (N > 1) ? $clog2(N) : 1;

  logic [PTR_W-1:0] ptr_q;
  logic [PTR_W-1:0] ptr_d;
  logic [PTR_W-1:0] win_c;
  int unsigned      idx_c;

  // Scan from the pointer, wrapping once; first requester wins.
  always_comb begin
    gnt_c     = '0;
    gnt_any_c = 1'b0;
    win_c     = '0;
    idx_c     = 0;
    for (int unsigned i = 0; i < N; i++) begin
      idx_c = 32'(ptr_q) + i;
      if (idx_c >= N) idx_c = idx_c - N;
      if (!gnt_any_c && req[PTR_W'(idx_c)]) begin
        gnt_c[PTR_W'(idx_c)] = 1'b1;
        gnt_any_c            = 1'b1;
        win_c                = PTR_W'(idx_c);
      end
    end
  end

  // Pointer advance: unit after the winner, wrapping at N.
  always_comb begin
    ptr_d = ptr_q;
    if (gnt_any_c) begin
      if (win_c == PTR_W'(N - 1)) ptr_d = '0;
      else                        ptr_d = win_c + PTR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) ptr_q <= '0;
    else      ptr_q <= ptr_d;
  end

endmodule

// File: rtl/fpu_wb_scheduler.sv
// FPU issue/writeback controller. Keeps a busy scoreboard of destination
// registers with writes in flight, stalls issue on RAW/WAW hazards, and
// arbitrates unit completions round-robin onto the single regfile write port.
// Optional build macro: FPU_WB_PERF_EN adds stall/conflict perf counters.
// Ports:
//   clk, rst                      : clock, asynchronous active-low reset
//   issue_valid/rd/rs1/rs2/uses_rs2 : op from decode
//   issue_ready                   : no hazard, op accepted (combinational)
//   rf_re                         : regfile read enable (combinational)
//   done_valid/rd/data            : per-unit completions, packed
//   done_ready                    : one-hot writeback grant (combinational)
//   rf_we/rf_waddr/rf_wdata       : regfile write port (registered)
//   busy_vec                      : scoreboard (registered)
//   perf_stall_cnt/perf_conflict_cnt : perf counters (FPU_WB_PERF_EN only)
module fpu_wb_scheduler
  import fpu_sched_pkg::*;
#(
  parameter int unsigned NUM_BITS  = 32,
  parameter int unsigned NUM_UNITS = 3,
  parameter int unsigned ADDR_W    = 5
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          issue_valid,
  input  logic [ADDR_W-1:0]             issue_rd,
  input  logic [ADDR_W-1:0]             issue_rs1,
  input  logic [ADDR_W-1:0]             issue_rs2,
  input  logic                          issue_uses_rs2,
  output logic                          issue_ready,
  output logic                          rf_re,
  input  logic [NUM_UNITS-1:0]          done_valid,
  input  logic [NUM_UNITS*ADDR_W-1:0]   done_rd,
  input  logic [NUM_UNITS*NUM_BITS-1:0] done_data,
  output logic [NUM_UNITS-1:0]          done_ready,
  output logic                          rf_we,
  output logic [ADDR_W-1:0]             rf_waddr,
  output logic [NUM_BITS-1:0]           rf_wdata,
  output logic [NUM_REGS-1:0]           busy_vec
`ifdef FPU_WB_PERF_EN
  ,
  output logic [31:0]                   perf_stall_cnt,
  output logic [31:0]                   perf_conflict_cnt
`endif
);

  localparam int unsigned SEL_W = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;

  logic [NUM_REGS-1:0]  busy_q;
  logic [NUM_REGS-1:0]  busy_d;
  logic                 hazard_c;
  logic [NUM_UNITS-1:0] arb_req_c;
  logic                 gnt_any_c;
  logic [ADDR_W-1:0]    sel_rd_c;
  logic [NUM_BITS-1:0]  sel_data_c;
  logic [ADDR_W-1:0]    unit_rd   [NUM_UNITS];
  logic [NUM_BITS-1:0]  unit_data [NUM_UNITS];

  // Hazard: any operand or the destination still has a write in flight.
  assign hazard_c    = busy_q[issue_rs1] | (issue_uses_rs2 & busy_q[issue_rs2]) | busy_q[issue_rd];
  assign issue_ready = ~hazard_c;
  assign rf_re       = issue_valid & issue_ready;
  assign busy_vec    = busy_q;

  // Completions are only arbitrated while something is outstanding.
  assign arb_req_c = done_valid & {NUM_UNITS{|busy_q}};

  fpu_rr_arbiter #(.N(NUM_UNITS)) u_arb (
    .clk       (clk),
    .rst       (rst),
    .req       (arb_req_c),
    .gnt_c     (done_ready),
    .gnt_any_c (gnt_any_c)
  );

  for (genvar g = 0; g < NUM_UNITS; g++) begin : g_unpack
    assign unit_rd[g]   = done_rd[g*ADDR_W +: ADDR_W];
    assign unit_data[g] = done_data[g*NUM_BITS +: NUM_BITS];
  end

  // One-hot grant -> AND-OR select of the winning unit's payload.
  always_comb begin
    sel_rd_c   = '0;
    sel_data_c = '0;
    for (int unsigned u = 0; u < NUM_UNITS; u++) begin
      if (done_ready[SEL_W'(u)]) begin
        sel_rd_c   = sel_rd_c   | unit_rd[SEL_W'(u)];
        sel_data_c = sel_data_c | unit_data[SEL_W'(u)];
      end
    end
  end

  // Clear on the write cycle, set on accept; a busy rd blocks issue so the
  // two never target the same register.
  always_comb begin
    busy_d = busy_q;
    if (rf_we) busy_d[rf_waddr] = 1'b0;
    if (rf_re) busy_d[issue_rd] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_q   <= '0;
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
    end else begin
      busy_q <= busy_d;
      rf_we  <= gnt_any_c;
      if (gnt_any_c) begin
        rf_waddr <= sel_rd_c;
        rf_wdata <= sel_data_c;
      end
    end
  end

`ifdef FPU_WB_PERF_EN
  logic multi_done_c;

  // More than one bit set: clearing the lowest set bit leaves something.
  assign multi_done_c = |(done_valid & (done_valid - NUM_UNITS'(1)));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_stall_cnt    <= '0;
      perf_conflict_cnt <= '0;
    end else begin
      if (issue_valid && !issue_ready) perf_stall_cnt <= perf_stall_cnt + 32'd1;
      if (multi_done_c)                perf_conflict_cnt <= perf_conflict_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fpu_wb_scheduler.sv
// Directed bench for fpu_wb_scheduler: reset, RAW/WAW stalls, rs2 masking,
// round-robin order and fairness, idle-scoreboard gating, mid-op reset.
module tb_fpu_wb_scheduler;
  import fpu_sched_pkg::*;

  localparam int unsigned NB = 32;
  localparam int unsigned NU = 3;

  logic              clk = 1'b0;
  logic              rst;
  logic              issue_valid;
  logic [ADDR_W-1:0] issue_rd, issue_rs1, issue_rs2;
  logic              issue_uses_rs2;
  logic              issue_ready, rf_re;
  logic [NU-1:0]     done_valid;
  logic [NU*ADDR_W-1:0] done_rd;
  logic [NU*NB-1:0]  done_data;
  logic [NU-1:0]     done_ready;
  logic              rf_we;
  logic [ADDR_W-1:0] rf_waddr;
  logic [NB-1:0]     rf_wdata;
  logic [31:0]       busy_vec;
`ifdef FPU_WB_PERF_EN
  logic [31:0]       perf_stall_cnt, perf_conflict_cnt;
`endif

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  fpu_wb_scheduler #(.NUM_BITS(NB), .NUM_UNITS(NU), .ADDR_W(ADDR_W)) dut (
    .clk            (clk),
    .rst            (rst),
    .issue_valid    (issue_valid),
    .issue_rd       (issue_rd),
    .issue_rs1      (issue_rs1),
    .issue_rs2      (issue_rs2),
    .issue_uses_rs2 (issue_uses_rs2),
    .issue_ready    (issue_ready),
    .rf_re          (rf_re),
    .done_valid     (done_valid),
    .done_rd        (done_rd),
    .done_data      (done_data),
    .done_ready     (done_ready),
    .rf_we          (rf_we),
    .rf_waddr       (rf_waddr),
    .rf_wdata       (rf_wdata),
    .busy_vec       (busy_vec)
`ifdef FPU_WB_PERF_EN
    ,
    .perf_stall_cnt    (perf_stall_cnt),
    .perf_conflict_cnt (perf_conflict_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic set_issue(input logic v, input reg_addr_t rd, input reg_addr_t rs1,
                           input reg_addr_t rs2, input logic u2);
    issue_valid = v; issue_rd = rd; issue_rs1 = rs1; issue_rs2 = rs2; issue_uses_rs2 = u2;
  endtask

  task automatic set_done(input logic [NU-1:0] v, input reg_addr_t r0, input reg_addr_t r1,
                          input reg_addr_t r2, input logic [NB-1:0] d0,
                          input logic [NB-1:0] d1, input logic [NB-1:0] d2);
    done_valid = v; done_rd = {r2, r1, r0}; done_data = {d2, d1, d0};
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    set_issue(1'b0, 0, 0, 0, 1'b0);
    set_done(3'b000, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    set_issue(1'b0, 0, 0, 0, 1'b0);
    set_done(3'b111, 1, 2, 3, 32'h11, 32'h22, 32'h33);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); #1;
      if (busy_vec !== 32'h0) begin n_err++; $display("FAIL rst_busy[%0d]: got %h want 0", k, busy_vec); end n_vec++;
      if (rf_we !== 1'b0) begin n_err++; $display("FAIL rst_we[%0d]: got %b want 0", k, rf_we); end n_vec++;
      if (done_ready !== 3'b000) begin n_err++; $display("FAIL rst_ready[%0d]: got %b want 000", k, done_ready); end n_vec++;
    end
    if (rf_waddr !== 5'd0) begin n_err++; $display("FAIL rst_waddr: got %0d want 0", rf_waddr); end n_vec++;
    if (rf_wdata !== 32'h0) begin n_err++; $display("FAIL rst_wdata: got %h want 0", rf_wdata); end n_vec++;
    @(negedge clk);
    rst = 1'b1;
    set_done(3'b000, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_raw();
    @(negedge clk); set_issue(1'b1, 5, 0, 0, 1'b0); #1;
    if (issue_ready !== 1'b1) begin n_err++; $display("FAIL raw_first_ready: got %b want 1", issue_ready); end n_vec++;
    if (rf_re !== 1'b1) begin n_err++; $display("FAIL raw_first_re: got %b want 1", rf_re); end n_vec++;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk); set_issue(1'b1, 6, 5, 0, 1'b0); #1;
      if (issue_ready !== 1'b0) begin n_err++; $display("FAIL raw_stall[%0d]: got %b want 0", k, issue_ready); end n_vec++;
      if (rf_re !== 1'b0) begin n_err++; $display("FAIL raw_stall_re[%0d]: got %b want 0", k, rf_re); end n_vec++;
    end
    if (busy_vec !== 32'h20) begin n_err++; $display("FAIL raw_busy: got %h want 00000020", busy_vec); end n_vec++;
    @(negedge clk); set_done(3'b001, 5, 0, 0, 32'h40000000, 0, 0); #1;
    if (done_ready !== 3'b001) begin n_err++; $display("FAIL raw_grant: got %b want 001", done_ready); end n_vec++;
    if (issue_ready !== 1'b0) begin n_err++; $display("FAIL raw_stall_grant: got %b want 0", issue_ready); end n_vec++;
    @(negedge clk); set_done(3'b000, 0, 0, 0, 0, 0, 0); #1;
    if (rf_we !== 1'b1 || rf_waddr !== 5'd5 || rf_wdata !== 32'h40000000) begin
      n_err++; $display("FAIL raw_write: got we=%b addr=%0d data=%h want we=1 addr=5 data=40000000", rf_we, rf_waddr, rf_wdata); end n_vec++;
    if (issue_ready !== 1'b0) begin n_err++; $display("FAIL raw_stall_wcycle: got %b want 0", issue_ready); end n_vec++;
    @(negedge clk); #1;
    if (issue_ready !== 1'b1) begin n_err++; $display("FAIL raw_release: got %b want 1", issue_ready); end n_vec++;
    if (rf_we !== 1'b0 || busy_vec !== 32'h0) begin
      n_err++; $display("FAIL raw_after: got we=%b busy=%h want we=0 busy=0", rf_we, busy_vec); end n_vec++;
    @(negedge clk); set_issue(1'b0, 0, 0, 0, 1'b0);
  endtask

  task automatic test_waw();
    @(negedge clk); set_issue(1'b1, 7, 1, 2, 1'b1); #1;
    if (issue_ready !== 1'b1) begin n_err++; $display("FAIL waw_first: got %b want 1", issue_ready); end n_vec++;
    @(negedge clk); set_issue(1'b1, 7, 3, 4, 1'b1); #1;
    if (issue_ready !== 1'b0) begin n_err++; $display("FAIL waw_stall: got %b want 0", issue_ready); end n_vec++;
    if (busy_vec !== 32'h80) begin n_err++; $display("FAIL waw_busy: got %h want 00000080", busy_vec); end n_vec++;
    @(negedge clk); set_done(3'b010, 0, 7, 0, 0, 32'h3F800000, 0); #1;
    if (done_ready !== 3'b010) begin n_err++; $display("FAIL waw_grant: got %b want 010", done_ready); end n_vec++;
    @(negedge clk); set_done(3'b000, 0, 0, 0, 0, 0, 0); #1;
    if (rf_we !== 1'b1 || rf_waddr !== 5'd7 || rf_wdata !== 32'h3F800000) begin
      n_err++; $display("FAIL waw_write: got we=%b addr=%0d data=%h want we=1 addr=7 data=3f800000", rf_we, rf_waddr, rf_wdata); end n_vec++;
    if (issue_ready !== 1'b0) begin n_err++; $display("FAIL waw_stall_wcycle: got %b want 0", issue_ready); end n_vec++;
    @(negedge clk); #1;
    if (issue_ready !== 1'b1 || rf_we !== 1'b0) begin
      n_err++; $display("FAIL waw_release: got ready=%b we=%b want ready=1 we=0", issue_ready, rf_we); end n_vec++;
    @(negedge clk); set_issue(1'b1, 8, 9, 7, 1'b1); #1;
    if (issue_ready !== 1'b0) begin n_err++; $display("FAIL rs2_hazard: got %b want 0", issue_ready); end n_vec++;
    @(negedge clk); set_issue(1'b1, 8, 9, 7, 1'b0); #1;
    if (issue_ready !== 1'b1) begin n_err++; $display("FAIL rs2_ignored: got %b want 1", issue_ready); end n_vec++;
    @(negedge clk); set_issue(1'b0, 0, 0, 0, 1'b0);
  endtask

  task automatic test_arbitration();
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk); set_issue(1'b1, reg_addr_t'(k), 0, 0, 1'b0); #1;
      if (issue_ready !== 1'b1) begin n_err++; $display("FAIL arb_issue[%0d]: got %b want 1", k, issue_ready); end n_vec++;
    end
    @(negedge clk); set_issue(1'b0, 0, 0, 0, 1'b0);
    set_done(3'b111, 1, 2, 3, 32'h11, 32'h22, 32'h33); #1;
    if (done_ready !== 3'b001) begin n_err++; $display("FAIL arb_g0: got %b want 001", done_ready); end n_vec++;
    if (busy_vec !== 32'hE) begin n_err++; $display("FAIL arb_busy0: got %h want 0000000e", busy_vec); end n_vec++;
    @(negedge clk); set_issue(1'b1, 9, 0, 0, 1'b0);
    set_done(3'b110, 1, 2, 3, 32'h11, 32'h22, 32'h33); #1;
    if (done_ready !== 3'b010) begin n_err++; $display("FAIL arb_g1: got %b want 010", done_ready); end n_vec++;
    if (rf_we !== 1'b1 || rf_waddr !== 5'd1 || rf_wdata !== 32'h11) begin
      n_err++; $display("FAIL arb_w1: got we=%b addr=%0d data=%h want we=1 addr=1 data=11", rf_we, rf_waddr, rf_wdata); end n_vec++;
    if (issue_ready !== 1'b1) begin n_err++; $display("FAIL arb_issue9: got %b want 1", issue_ready); end n_vec++;
    @(negedge clk); set_issue(1'b0, 0, 0, 0, 1'b0);
    set_done(3'b100, 1, 2, 3, 32'h11, 32'h22, 32'h33); #1;
    if (done_ready !== 3'b100) begin n_err++; $display("FAIL arb_g2: got %b want 100", done_ready); end n_vec++;
    if (rf_we !== 1'b1 || rf_waddr !== 5'd2 || rf_wdata !== 32'h22) begin
      n_err++; $display("FAIL arb_w2: got we=%b addr=%0d data=%h want we=1 addr=2 data=22", rf_we, rf_waddr, rf_wdata); end n_vec++;
    if (busy_vec !== 32'h20C) begin n_err++; $display("FAIL arb_set_clr: got %h want 0000020c", busy_vec); end n_vec++;
    @(negedge clk); set_done(3'b000, 0, 0, 0, 0, 0, 0); #1;
    if (rf_we !== 1'b1 || rf_waddr !== 5'd3 || rf_wdata !== 32'h33) begin
      n_err++; $display("FAIL arb_w3: got we=%b addr=%0d data=%h want we=1 addr=3 data=33", rf_we, rf_waddr, rf_wdata); end n_vec++;
    @(negedge clk); #1;
    if (rf_we !== 1'b0 || busy_vec !== 32'h200) begin
      n_err++; $display("FAIL arb_end: got we=%b busy=%h want we=0 busy=00000200", rf_we, busy_vec); end n_vec++;
  endtask

  task automatic test_fairness();
    @(negedge clk); set_issue(1'b1, 10, 0, 0, 1'b0);
    @(negedge clk); set_issue(1'b0, 0, 0, 0, 1'b0);
    set_done(3'b101, 20, 0, 21, 32'hA0, 0, 32'hA2); #1;
    if (done_ready !== 3'b001) begin n_err++; $display("FAIL fair_c0: got %b want 001", done_ready); end n_vec++;
    @(negedge clk); set_done(3'b101, 20, 0, 21, 32'hA0, 0, 32'hA2); #1;
    if (done_ready !== 3'b100) begin n_err++; $display("FAIL fair_c1: got %b want 100", done_ready); end n_vec++;
    if (rf_waddr !== 5'd20) begin n_err++; $display("FAIL fair_w0: got %0d want 20", rf_waddr); end n_vec++;
    @(negedge clk); set_done(3'b001, 20, 0, 0, 32'hA0, 0, 0); #1;
    if (done_ready !== 3'b001) begin n_err++; $display("FAIL fair_c2: got %b want 001", done_ready); end n_vec++;
    if (rf_waddr !== 5'd21 || rf_wdata !== 32'hA2) begin
      n_err++; $display("FAIL fair_w1: got addr=%0d data=%h want addr=21 data=a2", rf_waddr, rf_wdata); end n_vec++;
    @(negedge clk); #1;
    if (done_ready !== 3'b001) begin n_err++; $display("FAIL fair_c3: got %b want 001", done_ready); end n_vec++;
    @(negedge clk); set_done(3'b000, 0, 0, 0, 0, 0, 0); #1;
    if (done_ready !== 3'b000) begin n_err++; $display("FAIL fair_none: got %b want 000", done_ready); end n_vec++;
    @(negedge clk); set_done(3'b110, 20, 22, 0, 32'hA0, 32'hB1, 0); #1;
    if (done_ready !== 3'b010) begin n_err++; $display("FAIL fair_ptr_hold: got %b want 010", done_ready); end n_vec++;
    @(negedge clk); set_done(3'b000, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_idle_no_grant();
    @(negedge clk); set_done(3'b001, 3, 0, 0, 32'h55, 0, 0); #1;
    if (done_ready !== 3'b000) begin n_err++; $display("FAIL idle_grant: got %b want 000", done_ready); end n_vec++;
    @(negedge clk); set_issue(1'b1, 3, 0, 0, 1'b0); #1;
    if (rf_we !== 1'b0 || done_ready !== 3'b000) begin
      n_err++; $display("FAIL idle_write: got we=%b gnt=%b want we=0 gnt=000", rf_we, done_ready); end n_vec++;
    @(negedge clk); set_issue(1'b0, 0, 0, 0, 1'b0); #1;
    if (done_ready !== 3'b001 || busy_vec !== 32'h8) begin
      n_err++; $display("FAIL idle_wake: got gnt=%b busy=%h want gnt=001 busy=00000008", done_ready, busy_vec); end n_vec++;
    @(negedge clk); set_done(3'b000, 0, 0, 0, 0, 0, 0); #1;
    if (rf_we !== 1'b1 || rf_waddr !== 5'd3 || rf_wdata !== 32'h55) begin
      n_err++; $display("FAIL idle_w: got we=%b addr=%0d data=%h want we=1 addr=3 data=55", rf_we, rf_waddr, rf_wdata); end n_vec++;
    @(negedge clk); #1;
    if (busy_vec !== 32'h0) begin n_err++; $display("FAIL idle_clear: got %h want 0", busy_vec); end n_vec++;
  endtask

  task automatic test_mid_reset();
    @(negedge clk); set_issue(1'b1, 0, 1, 1, 1'b0);
    @(negedge clk); set_issue(1'b1, 5, 1, 1, 1'b0);
    @(negedge clk); set_issue(1'b0, 0, 0, 0, 1'b0);
    set_done(3'b001, 5, 0, 0, 32'hDEADBEEF, 0, 0);
    @(negedge clk); set_done(3'b010, 0, 0, 0, 0, 32'h12345678, 0); #1;
    if (rf_we !== 1'b1 || busy_vec !== 32'h21 || done_ready !== 3'b010) begin
      n_err++; $display("FAIL mr_pre: got we=%b busy=%h gnt=%b want we=1 busy=00000021 gnt=010", rf_we, busy_vec, done_ready); end n_vec++;
    #2 rst = 1'b0;
    #1;
    if (busy_vec !== 32'h0 || rf_we !== 1'b0 || done_ready !== 3'b000) begin
      n_err++; $display("FAIL mr_async: got busy=%h we=%b gnt=%b want busy=0 we=0 gnt=000", busy_vec, rf_we, done_ready); end n_vec++;
    if (rf_waddr !== 5'd0 || rf_wdata !== 32'h0) begin
      n_err++; $display("FAIL mr_port: got addr=%0d data=%h want 0/0", rf_waddr, rf_wdata); end n_vec++;
    @(negedge clk); rst = 1'b1; set_done(3'b000, 0, 0, 0, 0, 0, 0); #1;
    if (rf_we !== 1'b0) begin n_err++; $display("FAIL mr_post0: got %b want 0", rf_we); end n_vec++;
    @(negedge clk); #1;
    if (rf_we !== 1'b0 || busy_vec !== 32'h0) begin
      n_err++; $display("FAIL mr_post1: got we=%b busy=%h want we=0 busy=0", rf_we, busy_vec); end n_vec++;
  endtask

  initial begin
    test_reset();
    test_raw();
    do_reset();
    test_waw();
    do_reset();
    test_arbitration();
    do_reset();
    test_fairness();
    do_reset();
    test_idle_no_grant();
    do_reset();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fpu_wb_scheduler.md
Name: fpu_wb_scheduler

Overview:
- Issue/writeback controller for the 32-entry FPU register file. It holds a scoreboard of destination registers with pending writes and stalls issue on RAW/WAW hazards.
- It arbitrates completions from NUM_UNITS multi-cycle FPU units (add, mul, div/sqrt) onto the regfile's single write port.
- Position: between decode/issue and the regfile/FPU execution units.

Parameters:
- NUM_BITS, 32, regfile data width.
- NUM_UNITS, 3, number of FPU execution units competing for writeback.
- ADDR_W, 5, register address width (32 registers).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- issue_valid  in  1  decode presents an FPU op.
- issue_rd  in  ADDR_W  destination register.
- issue_rs1  in  ADDR_W  source register 1.
- issue_rs2  in  ADDR_W  source register 2.
- issue_uses_rs2  in  1  op reads rs2; ignore rs2 hazard when 0.
- issue_ready  out  1  op accepted this cycle; combinational.
- rf_re  out  1  regfile read enable; equals issue_valid & issue_ready.
- done_valid  in  NUM_UNITS  per-unit result available.
- done_rd  in  NUM_UNITS*ADDR_W  per-unit destination, packed.
- done_data  in  NUM_UNITS*NUM_BITS  per-unit result, packed.
- done_ready  out  NUM_UNITS  one-hot grant; combinational.
- rf_we  out  1  regfile write enable; registered.
- rf_waddr  out  ADDR_W  regfile write address; registered.
- rf_wdata  out  NUM_BITS  regfile write data; registered.
- busy_vec  out  32  scoreboard state; registered.

Behaviour:
- Reset is asynchronous, active-low. During reset: busy_vec=0, rf_we=0, rf_waddr=0, rf_wdata=0, RR pointer=0. Reset mid-operation drops all pending results. Units are reset from the same rst.
- Issue hazard: hazard = busy[rs1] | (issue_uses_rs2 & busy[rs2]) | busy[rd].
- issue_ready = ~hazard. It does not depend on issue_valid. There is no hardwired-zero register; f0 is scoreboarded like every other register.
- Accept: when issue_valid & issue_ready, busy[issue_rd] is set on the next edge.
- Arbitration: round-robin over done_valid, starting at the unit after the last granted unit.
  - At most one done_ready bit is high per cycle, and only for a valid requester.
  - The pointer advances only on a grant.
- Unit handshake: a unit holds done_valid/done_rd/done_data stable until it sees done_ready. The transfer occurs on the edge where valid & ready are both high.
- Writeback latency: on the edge after a grant, rf_we=1 with rf_waddr/rf_wdata taken from the granted unit.
  - rf_we stays high exactly one cycle per grant.
  - Back-to-back grants produce back-to-back writes at full throughput.
- Busy clear: busy[rf_waddr] clears on the edge that ends the rf_we cycle, i.e. the same edge the regfile captures the data. The next cycle's combinational read returns the new value and issue_ready reflects the clear.
- Simultaneous set and clear of the same register cannot occur: a busy rd blocks issue. A set and a clear of different registers in one cycle both take effect.
- No grant is given while the scoreboard is idle. Spurious done_valid for a non-busy rd is still written and the clear is a no-op.

Optional Feature:
- FPU_WB_PERF_EN: adds outputs perf_stall_cnt (32) and perf_conflict_cnt (32). Both reset to 0 and wrap at 2^32.
  - perf_stall_cnt increments each cycle with issue_valid & ~issue_ready.
  - perf_conflict_cnt increments each cycle where more than one done_valid bit is high.
- Without the macro, the ports and counters are absent. Core behaviour is identical either way.

Decomposition:
- Package fpu_sched_pkg holds:
  - constants ADDR_W=5 and NUM_REGS=32;
  - typedef reg_addr_t;
  - enum unit_id_t (UNIT_ADD, UNIT_MUL, UNIT_DIV).
- Sub-module fpu_rr_arbiter (NUM_UNITS-wide round-robin, req -> one-hot grant, pointer state) is instantiated once.

Test Plan:
- Reset: hold rst=0 for 3 cycles with done_valid=3'b111 -> busy_vec=0, rf_we=0, done_ready=0 throughout.
- RAW stall: issue rd=5, then rs1=5 next cycle -> issue_ready=0 until the cycle after rf_we with rf_waddr=5; then issue_ready=1.
- WAW stall: issue rd=7 twice -> second op stalls. Unit 1 returns 32'h3F800000 for rd=7 -> rf_we=1, rf_waddr=7, rf_wdata=32'h3F800000; stall releases the following cycle.
- Arbitration: done_valid=3'b111 held (rd=1,2,3) -> grants 001, 010, 100 in consecutive cycles; three consecutive rf_we pulses to addresses 1, 2, 3.
- Fairness: unit 0 requests continuously, unit 2 requests once -> unit 2 is granted within 2 cycles; unit 0 never gets 2 grants in a row while unit 2 waits.
- Mid-op reset: rst=0 while busy_vec=32'h00000021 and a grant is pending -> busy_vec=0 and rf_we=0 immediately (asynchronous); no write follows deassertion.
